// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-addressed reads to instruction memory,
// pre-decodes J-type jumps, and queues fetched words in a small FIFO for decode.
// A decode-side redirect flushes the queue and either retargets fetch at once
// or, if a read is still in flight, waits in DISCARD to drop its stale response.
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] start_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    FETCH,
    DISCARD
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;          // address of the current/next request
  logic [31:0]   target_q, target_d;  // redirect target latched during DISCARD
  logic          hold_q, hold_d;      // a request is outstanding and unacked
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;

  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];

  logic          ack;
  logic          push;
  logic          pop;
  logic          flush;

  // A held request always stays up; a new one needs a free buffer slot.
  // Reset masks the request so a memory never sees one while reset is high.
  assign imem_req   = !reset && (hold_q || (count_q < CW'(DEPTH)));
  assign imem_addr  = pc_q;
  assign ack        = imem_req && imem_ack;
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? buf_data[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr_q]   : '0;
  assign pop        = inst_valid && inst_ready && !redirect;

  // Next-state logic: redirect outranks ack, and an ack in DISCARD is dropped.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    hold_d   = hold_q;
    push     = 1'b0;
    flush    = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      if (ack || !imem_req) begin
        pc_d    = redirect_pc;
        state_d = FETCH;
        hold_d  = 1'b0;
      end else begin
        target_d = redirect_pc;
        state_d  = DISCARD;
        hold_d   = 1'b1;
      end
    end else if (ack) begin
      hold_d = 1'b0;
      if (state_q == DISCARD) begin
        pc_d    = target_q;
        state_d = FETCH;
      end else begin
        push = 1'b1;
        if (imem_rdata[31:26] == 6'd2) begin
          pc_d = {pc_q[31:26], imem_rdata[25:0]};
        end else begin
          pc_d = pc_q + 32'd1;
        end
      end
    end else if (imem_req) begin
      hold_d = 1'b1;
    end
  end

  // Control state and queue pointers, synchronously reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= start_pc;
      target_q <= '0;
      hold_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Queue storage written on push.
  // NOTE: the storage array is deliberately not reset; entries are only
  // observable through inst_valid, which the reset counter already clears.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_q] <= imem_rdata;
      buf_pc[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (DEPTH=2). Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] start_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        auto_ack;   // zero-wait memory: ack every request immediately
  logic        man_ack;    // hand-driven ack when auto_ack is low

  int          n_checks = 0;
  int          n_errors = 0;
  int          pops;
  logic [31:0] exp_pc;
  logic [31:0] held;

  fetch_unit #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_pc    (start_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // Memory contents: one J instruction at 0x20, tagged plain words elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h20) return 32'h0800_0040;
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = word_at(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Run n cycles; every instruction accepted by decode must be the next in order.
  task automatic tick_collect(input int n);
    repeat (n) begin
      #1;
      if (inst_valid && inst_ready) begin
        check("stream_pc", inst_pc, exp_pc);
        check("stream_data", inst_data, word_at(exp_pc));
        exp_pc = exp_pc + 32'd1;
        pops++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start_pc = 32'h10; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; auto_ack = 1'b0; man_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h10);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_data",  inst_data, 32'd0);
    check("rst_pc",    inst_pc, 32'd0);
    @(negedge clk);

    // Zero-wait streaming from 0x10.
    reset = 1'b0; auto_ack = 1'b1; inst_ready = 1'b1;
    exp_pc = 32'h10; pops = 0;
    tick_collect(10);
    check("throughput", {31'd0, pops >= 5}, 32'd1);

    // Backpressure: fill, then drain with fetch starved.
    inst_ready = 1'b0;
    tick_collect(6);
    #1;
    check("full_req",   {31'd0, imem_req}, 32'd0);
    check("full_valid", {31'd0, inst_valid}, 32'd1);
    @(negedge clk);
    auto_ack = 1'b0; inst_ready = 1'b1; pops = 0;
    tick_collect(6);
    check("drain_count", pops, 32'd2);
    #1;
    check("held_req",  {31'd0, imem_req}, 32'd1);
    check("held_addr", imem_addr, exp_pc);
    held = exp_pc;
    @(negedge clk);

    // Redirect while outstanding (twice, second overwrites), then late ack.
    redirect = 1'b1; redirect_pc = 32'h180;
    @(negedge clk);
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("disc_valid", {31'd0, inst_valid}, 32'd0);
    check("disc_req",   {31'd0, imem_req}, 32'd1);
    check("disc_addr",  imem_addr, held);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    check("stale_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_req",   {31'd0, imem_req}, 32'd1);
    check("redir_addr",  imem_addr, 32'h100);
    @(negedge clk);
    auto_ack = 1'b1; exp_pc = 32'h100; pops = 0;
    tick_collect(4);
    check("redir_pops", {31'd0, pops >= 2}, 32'd1);

    // Jump pre-decode at 0x20.
    auto_ack = 1'b0; inst_ready = 1'b0; reset = 1'b1; start_pc = 32'h20;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("jmp_req",  {31'd0, imem_req}, 32'd1);
    check("jmp_addr", imem_addr, 32'h20);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    check("jmp_target", imem_addr, 32'h40);
    check("jmp_valid",  {31'd0, inst_valid}, 32'd1);
    check("jmp_pc",     inst_pc, 32'h20);
    check("jmp_data",   inst_data, 32'h0800_0040);
    @(negedge clk);

    // Redirect coincident with ack and pop.
    inst_ready = 1'b1; man_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    inst_ready = 1'b0; man_ack = 1'b0; redirect = 1'b0;
    #1;
    check("coin_valid", {31'd0, inst_valid}, 32'd0);
    check("coin_req",   {31'd0, imem_req}, 32'd1);
    check("coin_addr",  imem_addr, 32'h200);
    @(negedge clk);

    // PC wrap at 0xFFFFFFFF.
    reset = 1'b1; start_pc = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    check("wrap_pc",    inst_pc, 32'hFFFF_FFFF);
    @(negedge clk);

    // Reset mid-stream.
    auto_ack = 1'b1; inst_ready = 1'b1; start_pc = 32'h40;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_req",   {31'd0, imem_req}, 32'd0);
    check("mid_addr",  imem_addr, 32'h40);
    check("mid_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_data",  inst_data, 32'd0);
    check("mid_pc",    inst_pc, 32'd0);
    @(negedge clk);
    auto_ack = 1'b0; reset = 1'b0;
    #1;
    check("post_req",  {31'd0, imem_req}, 32'd1);
    check("post_addr", imem_addr, 32'h40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction buffer entries; legal values are powers of 2 with DEPTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_pc  input  32  word address loaded into fetch PC while reset is high.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word address of the current request.
REQ-007 imem_ack  input  1  memory response strobe; ignored unless imem_req is high.
REQ-008 imem_rdata  input  32  instruction word; valid only in an acknowledged cycle.
REQ-009 inst_valid  output  1  buffer head holds an instruction for decode.
REQ-010 inst_data  output  32  instruction at buffer head.
REQ-011 inst_pc  output  32  word address of inst_data.
REQ-012 inst_ready  input  1  decode accepts head; pop when inst_valid && inst_ready.
REQ-013 redirect  input  1  decode-side branch/exception redirect.
REQ-014 redirect_pc  input  32  new fetch word address, sampled when redirect is high.

Function
REQ-015 PC arithmetic is word-based: sequential next PC = fetched address + 1, modulo 2^32; 0xFFFFFFFF wraps to 0x00000000.
REQ-016 States: FETCH (issue/hold requests) and DISCARD (await and drop one stale response); reset state is FETCH.
REQ-017 In FETCH, imem_req asserts only when buffer occupancy + outstanding requests < DEPTH; at most one request is outstanding.
REQ-018 Once asserted, imem_req and imem_addr hold stable until the cycle imem_ack is high; an ack in the same cycle as the request assertion is legal (zero-wait memory).
REQ-019 On an ack without redirect: push {imem_rdata, imem_addr} into the buffer; the next request may issue in the following cycle.
REQ-020 Jump pre-decode: if imem_rdata[31:26] == 6'd2, next fetch PC = {imem_addr[31:26], imem_rdata[25:0]}; otherwise imem_addr + 1; the J word itself is still pushed.
REQ-021 Buffer is FIFO order, DEPTH entries, with pointers wrapping modulo DEPTH; a simultaneous push and pop leaves occupancy unchanged; a push never finds the buffer full (guaranteed by REQ-017).
REQ-022 inst_valid = occupancy != 0; inst_data and inst_pc are registered buffer contents, stable while inst_valid && !inst_ready.
REQ-023 Redirect has priority over every other event; in the redirect cycle the buffer is flushed, so inst_valid is 0 next cycle, and any pop in that cycle has no further effect.
REQ-024 Redirect with no request outstanding: fetch PC <= redirect_pc; the state stays FETCH.
REQ-025 Redirect with a request outstanding and imem_ack low: go to DISCARD, latch redirect_pc, and keep imem_req and imem_addr held per REQ-018.
REQ-026 Redirect in the same cycle as imem_ack: drop imem_rdata, fetch PC <= redirect_pc, and stay in FETCH.
REQ-027 In DISCARD, the ack response is dropped (not pushed) and the state returns to FETCH with fetch PC = the latched target; a further redirect in DISCARD overwrites the latched target.
REQ-028 A redirect to the same address as the dropped fetch still refetches; there is no forwarding.

Reset
REQ-029 While reset is high: the state is FETCH, the fetch PC is start_pc, the buffer is empty, and no request is outstanding.
REQ-030 Output reset values: imem_req=0, imem_addr=start_pc, inst_valid=0, inst_data=0, inst_pc=0.
REQ-031 Reset asserted mid-request abandons the request; the memory model must tolerate a dropped request; the first request is issued in the first cycle after reset deasserts.

Verification
REQ-032 Zero-wait streaming: start_pc=0x10, ack every request, inst_ready=1 -> inst_pc sequence 0x10, 0x11, 0x12...; throughput is one instruction every 2 cycles or better; order is preserved.
REQ-033 Backpressure: inst_ready=0 -> exactly DEPTH entries are buffered, imem_req stays 0 while full, and there is no loss or duplication after inst_ready=1.
REQ-034 Jump: word 0x08000040 at 0x20 -> the next imem_addr is 0x00000040; 0x08000040 is still delivered with inst_pc=0x20.
REQ-035 Redirect while outstanding: ack delayed 3 cycles, redirect_pc=0x100 -> the stale data is never visible, and the next request address is 0x100.
REQ-036 Redirect coincident with ack and with pop -> the buffer is empty next cycle, and the next imem_addr is redirect_pc.
REQ-037 Wrap: start_pc=0xFFFFFFFF -> the second request address is 0x00000000; reset mid-stream -> outputs return to the REQ-030 values the next cycle.
